// File: rtl/router_pkg.sv
// Shared types for the packet-switched router: flit encodings,
// output arbiter states and flit-type decode.
package router_pkg;

  typedef enum logic [1:0] {
    BODY   = 2'b00,
    TAIL   = 2'b01,
    HEADER = 2'b10,
    SINGLE = 2'b11
  } flit_type_t;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Takes the two type bits, i.e. flit[Width-1:Width-2].
  function automatic flit_type_t flit_type(input logic [1:0] msbs);
    return flit_type_t'(msbs);
  endfunction

endpackage

// File: rtl/router_rr_arbiter.sv
// Combinational round-robin picker: first set request at or
// after ptr, wrapping, found by scanning a doubled request vector.
module router_rr_arbiter
  import router_pkg::*;
#(
  parameter  int N  = 5,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  winner,
  output logic          valid
);

  logic [2*N-1:0] dbl;

  always_comb begin
    dbl    = {req, req};
    winner = '0;
    valid  = 1'b0;
    for (int k = 0; k < 2 * N; k++) begin
      if (!valid && k >= int'(ptr) &&
          k < int'(ptr) + N && dbl[k]) begin
        valid         = 1'b1;
        winner[k % N] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/router_output_arbiter.sv
// Wormhole output-port allocator: round-robin grant held from
// header to tail, pops the owner only when downstream has room.
module router_output_arbiter
  import router_pkg::*;
#(
  parameter  int NumInputs = 5,
  parameter  int Width     = 66,
  localparam int PW = (NumInputs > 1) ? $clog2(NumInputs) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NumInputs-1:0] in_empty,
  input  logic [Width-1:0]     in_data [NumInputs],
  input  logic [NumInputs-1:0] in_req,
  output logic [NumInputs-1:0] in_rdreq,
  input  logic                 out_full,
  output logic                 out_wrreq,
  output logic [Width-1:0]     out_data,
  output logic [NumInputs-1:0] grant
);

  arb_state_t           state_q, state_d;
  logic [NumInputs-1:0] grant_q, grant_d;
  logic [PW-1:0]        rr_ptr_q, rr_ptr_d;

  logic [NumInputs-1:0] elig, non_hdr, win;
  logic                 win_vld;
  logic [PW-1:0]        gidx;
  logic [Width-1:0]     gdata;
  logic                 g_empty;
  logic                 fire;
  flit_type_t           gtype;

  always_comb begin
    elig    = '0;
    non_hdr = '0;
    for (int i = 0; i < NumInputs; i++) begin
      non_hdr[i] = !(flit_type(in_data[i][Width-1 -: 2])
                     inside {HEADER, SINGLE});
      elig[i] = in_req[i] & ~in_empty[i] & ~non_hdr[i];
    end
  end

  router_rr_arbiter #(.N(NumInputs)) u_rr (
    .req    (elig),
    .ptr    (rr_ptr_q),
    .winner (win),
    .valid  (win_vld)
  );

  always_comb begin
    gidx    = '0;
    gdata   = '0;
    g_empty = 1'b1;
    for (int i = 0; i < NumInputs; i++) begin
      if (grant_q[i]) begin
        gidx    = PW'(i);
        gdata   = in_data[i];
        g_empty = in_empty[i];
      end
    end
  end

  assign fire  = (state_q == LOCKED) & ~g_empty & ~out_full;
  assign gtype = flit_type(gdata[Width-1 -: 2]);
  assign grant = grant_q;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    in_rdreq  = '0;
    out_wrreq = 1'b0;
    out_data  = '0;
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          grant_d = win;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (fire) begin
          out_wrreq = 1'b1;
          in_rdreq  = grant_q;
          out_data  = gdata;
          // Packet ends: release and move priority past the owner.
          if (gtype == TAIL || gtype == SINGLE) begin
            state_d  = IDLE;
            grant_d  = '0;
            rr_ptr_d = (int'(gidx) == NumInputs - 1) ?
                       '0 : gidx + PW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  a_grant_oh: assert property (@(posedge clk) disable iff (rst)
    $onehot0(grant_q));
  a_rdreq_oh: assert property (@(posedge clk) disable iff (rst)
    $onehot0(in_rdreq));
  a_wr_full: assert property (@(posedge clk) disable iff (rst)
    out_wrreq |-> !out_full);
  a_rd_own: assert property (@(posedge clk) disable iff (rst)
    (in_rdreq & ~(grant_q & ~in_empty)) == '0);
  a_idle_hdr: assert property (@(posedge clk) disable iff (rst)
    (state_q == IDLE) |-> ((in_req & ~in_empty & non_hdr) == '0));

endmodule

// File: tb/tb_router_output_arbiter.sv
// Bench for router_output_arbiter: vector table, directed
// sequences and random traffic against a queue-based model.
module tb_router_output_arbiter;

  localparam int N = 5;
  localparam int W = 66;

  typedef logic [W-1:0] flit_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] in_empty, in_req, in_rdreq, grant;
  flit_t        in_data [N];
  logic         out_full, out_wrreq;
  flit_t        out_data;

  router_output_arbiter #(.NumInputs(N), .Width(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_empty  (in_empty),
    .in_data   (in_data),
    .in_req    (in_req),
    .in_rdreq  (in_rdreq),
    .out_full  (out_full),
    .out_wrreq (out_wrreq),
    .out_data  (out_data),
    .grant     (grant)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model state: per-input FIFO contents, owner (-1 = none), priority.
  flit_t        fq [N][$];
  logic [N-1:0] stall_v, reqm_v;
  logic         full_v;
  int           owner, rr, cycles, pkt_id;
  int           winners [$];

  typedef struct {
    logic [N-1:0] emp;
    flit_t        d0;
    logic [N-1:0] req;
    logic         full;
    logic [N-1:0] eg;
    logic         ew;
    logic [N-1:0] er;
    flit_t        ed;
  } vec_t;

  vec_t tbl [6];

  function automatic flit_t mk(logic [1:0] t, int id);
    return {t, 64'(id)};
  endfunction

  task automatic chk(string nm, flit_t act, flit_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic push_pkt(int i, int len);
    pkt_id++;
    if (len == 1) fq[i].push_back(mk(2'b11, pkt_id * 16));
    else begin
      fq[i].push_back(mk(2'b10, pkt_id * 16));
      for (int b = 1; b < len - 1; b++)
        fq[i].push_back(mk(2'b00, pkt_id * 16 + b));
      fq[i].push_back(mk(2'b01, pkt_id * 16 + len - 1));
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      in_empty[i] = (fq[i].size() == 0) | stall_v[i];
      in_data[i]  = (fq[i].size() != 0) ? fq[i][0] : '0;
      in_req[i]   = (fq[i].size() != 0) && fq[i][0][W-1] && reqm_v[i];
    end
    out_full = full_v;
  endtask

  function automatic bit busy();
    if (owner >= 0) return 1'b1;
    for (int i = 0; i < N; i++)
      if (fq[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  // One clock: drive, predict from packet-level rules, compare, advance.
  task automatic cyc();
    logic [N-1:0] eg, er;
    logic         ew;
    flit_t        ed;
    int           nxt;
    drive();
    #2;
    eg = '0; er = '0; ew = 1'b0; ed = '0; nxt = -1;
    if (owner < 0) begin
      for (int k = 0; k < N; k++) begin
        int i = (rr + k) % N;
        if (nxt < 0 && in_req[i] && !in_empty[i] && in_data[i][W-1])
          nxt = i;
      end
    end else begin
      eg[owner] = 1'b1;
      if (!in_empty[owner] && !full_v) begin
        ew = 1'b1;
        er[owner] = 1'b1;
        ed = fq[owner][0];
      end
    end
    chk("grant", flit_t'(grant), flit_t'(eg));
    chk("out_wrreq", flit_t'(out_wrreq), flit_t'(ew));
    chk("in_rdreq", flit_t'(in_rdreq), flit_t'(er));
    chk("out_data", out_data, ed);
    if (owner < 0) begin
      if (nxt >= 0) begin
        owner = nxt;
        winners.push_back(nxt);
      end
    end else if (ew) begin
      void'(fq[owner].pop_front());
      if (ed[W-2]) begin
        rr = (owner + 1) % N;
        owner = -1;
      end
    end
    cycles++;
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) fq[i].delete();
    owner = -1;
    rr = 0;
    winners.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    stall_v = '0;
    full_v = 1'b0;
    reqm_v = '1;
    model_clear();
    drive();
    #3;
    chk("rst_grant", flit_t'(grant), '0);
    chk("rst_wrreq", flit_t'(out_wrreq), '0);
    chk("rst_rdreq", flit_t'(in_rdreq), '0);
    chk("rst_data", out_data, '0);
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(int maxc);
    int c = 0;
    stall_v = '0;
    full_v = 1'b0;
    reqm_v = '1;
    while (busy() && c < maxc) begin
      cyc();
      c++;
    end
    total++;
    if (busy()) begin
      bad++;
      $display("FAIL drain_timeout got=%0d want<%0d", c, maxc);
    end
  endtask

  task automatic chk_win(string nm, int n, int a, int b, int c);
    int e [3];
    bit ok;
    e[0] = a; e[1] = b; e[2] = c;
    ok = (winners.size() == n);
    for (int i = 0; i < n && ok; i++)
      if (winners[i] != e[i]) ok = 1'b0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s got_n=%0d first=%0d want=%0d,%0d,%0d", nm,
               winners.size(),
               (winners.size() != 0) ? winners[0] : -1, a, b, c);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    flit_t h, b1, b2, t;
    int c0;
    h  = mk(2'b10, 100);
    b1 = mk(2'b00, 101);
    b2 = mk(2'b00, 102);
    t  = mk(2'b01, 103);
    tbl[0] = '{5'b11110, h,  5'b00001, 1'b0, 5'b00000, 1'b0, 5'b00000, '0};
    tbl[1] = '{5'b11110, h,  5'b00001, 1'b0, 5'b00001, 1'b1, 5'b00001, h};
    tbl[2] = '{5'b11110, b1, 5'b00000, 1'b0, 5'b00001, 1'b1, 5'b00001, b1};
    tbl[3] = '{5'b11110, b2, 5'b00000, 1'b0, 5'b00001, 1'b1, 5'b00001, b2};
    tbl[4] = '{5'b11110, t,  5'b00000, 1'b0, 5'b00001, 1'b1, 5'b00001, t};
    tbl[5] = '{5'b11111, '0, 5'b00000, 1'b0, 5'b00000, 1'b0, 5'b00000, '0};
    pkt_id = 0;
    cycles = 0;
    do_reset();

    for (int v = 0; v < 6; v++) begin
      in_empty = tbl[v].emp;
      for (int i = 0; i < N; i++) in_data[i] = '0;
      in_data[0] = tbl[v].d0;
      in_req = tbl[v].req;
      out_full = tbl[v].full;
      #2;
      chk("tbl_grant", flit_t'(grant), flit_t'(tbl[v].eg));
      chk("tbl_wrreq", flit_t'(out_wrreq), flit_t'(tbl[v].ew));
      chk("tbl_rdreq", flit_t'(in_rdreq), flit_t'(tbl[v].er));
      chk("tbl_data", out_data, tbl[v].ed);
      @(posedge clk);
      #1;
    end

    do_reset();
    push_pkt(1, 2); push_pkt(1, 2); push_pkt(3, 2);
    drain(40);
    chk_win("rr_fair", 3, 1, 3, 1);

    do_reset();
    push_pkt(3, 2);
    drain(20);
    push_pkt(0, 2); push_pkt(4, 2);
    drain(20);
    chk_win("rr_wrap", 3, 3, 4, 0);

    do_reset();
    push_pkt(0, 4);
    cyc(); cyc();
    full_v = 1'b1;
    repeat (3) cyc();
    drain(20);
    chk_win("stall_full", 1, 0, -1, -1);

    do_reset();
    push_pkt(2, 3); push_pkt(4, 2);
    cyc(); cyc(); cyc();
    stall_v = 5'b00100;
    repeat (2) cyc();
    drain(20);
    chk_win("stall_empty", 2, 2, 4, -1);

    do_reset();
    push_pkt(2, 1); push_pkt(2, 1); push_pkt(2, 1);
    c0 = cycles;
    drain(20);
    chk("single_cycles", flit_t'(cycles - c0), flit_t'(6));
    chk_win("single_win", 3, 2, 2, 2);

    do_reset();
    push_pkt(2, 2);
    drain(20);
    push_pkt(0, 4);
    cyc(); cyc(); cyc();
    #2 rst = 1'b1;
    #1;
    chk("arst_grant", flit_t'(grant), '0);
    chk("arst_wrreq", flit_t'(out_wrreq), '0);
    chk("arst_rdreq", flit_t'(in_rdreq), '0);
    model_clear();
    drive();
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    push_pkt(1, 2); push_pkt(3, 2);
    drain(20);
    chk_win("arst_rr0", 2, 1, 3, -1);

    do_reset();
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < N; i++)
        if (fq[i].size() == 0 && $urandom_range(0, 3) == 0)
          push_pkt(i, int'($urandom_range(1, 4)));
      for (int i = 0; i < N; i++) begin
        stall_v[i] = ($urandom_range(0, 7) == 0);
        reqm_v[i]  = ($urandom_range(0, 7) != 0);
      end
      full_v = ($urandom_range(0, 3) == 0);
      cyc();
    end
    drain(300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
